// File: rtl/mac_share_arb.sv
// mac_share_arb: N requesters share one registered multiply-accumulate
// (res_data = a*b + c) through a two-stage pipeline: operand register (s1)
// then result register (s2). Each result is tagged with the issuing index.
// Build option: define MAC_FIXED_PRIO_EN for fixed lowest-index-wins
// arbitration; the default build uses a round-robin arbiter.
module mac_share_arb #(
  parameter int N        = 4,
  parameter int SIZE     = 8,
  parameter int SIZE_OUT = 2*SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid,
  output logic [N-1:0]           req_ready,
  input  logic [N*SIZE-1:0]      req_a,
  input  logic [N*SIZE-1:0]      req_b,
  input  logic [N*SIZE-1:0]      req_c,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [SIZE_OUT-1:0]    res_data,
  output logic [$clog2(N)-1:0]   res_id
);
  localparam int IDW = $clog2(N);

  logic            adv1;
  logic            adv2;
  logic            found;
  logic            xfer;
  logic [IDW-1:0]  grant;
  logic [IDW-1:0]  cand;

  logic            s1_v;
  logic [SIZE-1:0] s1_a;
  logic [SIZE-1:0] s1_b;
  logic [SIZE-1:0] s1_c;
  logic [IDW-1:0]  s1_id;

`ifndef MAC_FIXED_PRIO_EN
  logic [IDW-1:0]  last_grant;
`endif

  // Stage enables: a stage may load when it is empty or its contents move on.
  assign adv2 = !res_valid || res_ready;
  assign adv1 = !s1_v || adv2;

  // Arbiter: pick the first requesting index in priority order.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
`ifdef MAC_FIXED_PRIO_EN
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDW'(k);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
`else
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDW'((32'(last_grant) + k) % N);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
`endif
  end

  assign xfer = !rst && found && adv1;

  // Ready is one-hot on the granted requester, only when s1 can accept.
  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant] = 1'b1;
  end

  // Pipeline registers and arbitration pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
`ifndef MAC_FIXED_PRIO_EN
      last_grant <= IDW'(N-1);
`endif
    end else begin
      if (adv1) begin
        s1_v <= found;
        if (found) begin
          s1_a  <= req_a[grant*SIZE +: SIZE];
          s1_b  <= req_b[grant*SIZE +: SIZE];
          s1_c  <= req_c[grant*SIZE +: SIZE];
          s1_id <= grant;
`ifndef MAC_FIXED_PRIO_EN
          last_grant <= grant;
`endif
        end
      end
      if (adv2) begin
        res_valid <= s1_v;
        res_data  <= SIZE_OUT'(s1_a) * SIZE_OUT'(s1_b) + SIZE_OUT'(s1_c);
        res_id    <= s1_id;
      end
    end
  end
endmodule

// File: tb/tb_mac_share_arb.sv
// Scoreboard bench for mac_share_arb: directed scenarios followed by random
// traffic, checked against an arbitration/occupancy reference model.
module tb_mac_share_arb;
  localparam int N        = 4;
  localparam int SIZE     = 8;
  localparam int SIZE_OUT = 16;
  localparam int IDW      = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_ready;
  logic [N*SIZE-1:0]    req_a = '0;
  logic [N*SIZE-1:0]    req_b = '0;
  logic [N*SIZE-1:0]    req_c = '0;
  logic                 res_valid;
  logic                 res_ready = 1'b1;
  logic [SIZE_OUT-1:0]  res_data;
  logic [IDW-1:0]       res_id;

  mac_share_arb #(.N(N), .SIZE(SIZE), .SIZE_OUT(SIZE_OUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int data;
    int cyc;
  } item_t;

  item_t        q[$];
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           n_in = 0;
  int           n_out = 0;
  int           ptr = N-1;
  logic [N-1:0] pend = '0;
  logic [N-1:0] took = '0;
  int           oa[N];
  int           ob[N];
  int           oc[N];
  logic         prev_rst = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: rotate from the index after the last winner.
  function automatic int model_grant(logic [N-1:0] v, int p);
    logic [N-1:0] t;
`ifdef MAC_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) begin
      t = v >> i;
      if (t[0]) return i;
    end
`else
    for (int k = 1; k <= N; k++) begin
      t = v >> ((p + k) % N);
      if (t[0]) return (p + k) % N;
    end
`endif
    return -1;
  endfunction

  // Input side: predict req_ready and enqueue the expected result per grant.
  always @(negedge clk) begin
    int inflight;
    int g;
    logic can;
    logic [N-1:0] er;
    if (rst) begin
      chk("ready_in_reset", int'(req_ready), 0);
      q.delete();
      n_in <= 0;
      ptr = N-1;
      took <= '0;
    end else begin
      inflight = n_in - n_out;
      can = !(inflight >= 2 && !res_ready);
      g = model_grant(pend, ptr);
      er = '0;
      if (g >= 0 && can) er = N'(1) << g;
      chk("req_ready", int'(req_ready), int'(er));
      took <= req_valid & req_ready;
      if (g >= 0 && can) begin
        q.push_back('{id: g, data: oa[g]*ob[g] + oc[g], cyc: cyc});
        ptr = g;
        n_in <= n_in + 1;
      end
    end
  end

  // Output side: the head item must be presented exactly from two cycles
  // after acceptance, and held until taken.
  always @(negedge clk) begin
    logic ev;
    if (rst) begin
      n_out <= 0;
      if (prev_rst) begin
        chk("res_valid_in_reset", int'(res_valid), 0);
        chk("res_data_in_reset", int'(res_data), 0);
        chk("res_id_in_reset", int'(res_id), 0);
      end
      prev_rst <= 1'b1;
    end else begin
      ev = (q.size() > 0) && (cyc - q[0].cyc >= 2);
      chk(prev_rst ? "res_valid_after_rst" : "res_valid", int'(res_valid), int'(ev));
      if (res_valid && ev) begin
        chk("res_data", int'(res_data), q[0].data);
        chk("res_id", int'(res_id), q[0].id);
        if (res_ready) begin
          void'(q.pop_front());
          n_out <= n_out + 1;
        end
      end
      prev_rst <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    pend = pend & ~took;
  endtask

  task automatic issue(int i, int a, int b, int c);
    logic [N-1:0] t;
    t = pend >> i;
    if (!t[0]) begin
      pend = pend | (N'(1) << i);
      oa[i] = a;
      ob[i] = b;
      oc[i] = c;
    end
  endtask

  task automatic drive();
    req_valid = pend;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    for (int i = 0; i < N; i++) begin
      req_a = req_a | ((N*SIZE)'(oa[i]) << (i*SIZE));
      req_b = req_b | ((N*SIZE)'(ob[i]) << (i*SIZE));
      req_c = req_c | ((N*SIZE)'(oc[i]) << (i*SIZE));
    end
  endtask

  task automatic fill(int pct);
    for (int i = 0; i < N; i++)
      if ($urandom_range(99) < pct)
        issue(i, $urandom_range(255), $urandom_range(255), $urandom_range(255));
  endtask

  // rdy_pct < 0 leaves res_ready untouched.
  task automatic run(int cycles, int fill_pct, int rdy_pct);
    repeat (cycles) begin
      if (fill_pct > 0) fill(fill_pct);
      if (rdy_pct >= 0) res_ready = ($urandom_range(99) < rdy_pct);
      drive();
      tick();
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    drive();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int waited;
    for (int i = 0; i < N; i++) begin
      oa[i] = 0; ob[i] = 0; oc[i] = 0;
    end
    // Reset for two clocks with every requester asking.
    rst = 1'b1;
    res_ready = 1'b1;
    fill(100);
    drive();
    repeat (2) begin
      tick();
      drive();
    end
    // Single requester 1: 3*4+5.
    rst = 1'b0;
    pend = '0;
    issue(1, 3, 4, 5);
    run(6, 0, 100);
    // All requesters streaming from a fresh pointer.
    pulse_rst();
    run(12, 100, 100);
    run(8, 0, 100);
    // Backpressure for five clocks mid-stream.
    run(4, 100, 100);
    res_ready = 1'b0;
    run(5, 100, -1);
    res_ready = 1'b1;
    run(6, 100, -1);
    run(10, 0, -1);
    // Operand extremes.
    issue(0, 255, 255, 255);
    issue(2, 0, 200, 0);
    run(6, 0, 100);
    // Reset with results in flight, then re-arbitrate.
    run(3, 100, 100);
    pulse_rst();
    run(6, 100, 100);
    run(10, 0, 100);
    // Random traffic with occasional resets.
    repeat (3000) begin
      if ($urandom_range(499) == 0) pulse_rst();
      else run(1, 40, 70);
    end
    // Drain everything outstanding.
    res_ready = 1'b1;
    waited = 0;
    while ((pend != '0 || q.size() != 0) && waited < 100) begin
      drive();
      tick();
      waited++;
    end
    chk("drain_complete", int'(pend == '0 && q.size() == 0), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
